fetch_decode_unit: RTL and testbench
====================================

FETCH_DECODE_UNIT -- requirements
Module: fetch_decode_unit

Interface
REQ-001 Parameter MEM_WORDS, default 16384, sets instruction memory depth in 32-bit words (power of two).
REQ-002 clock  in  1  sole clock; all state updates on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high; clears all pipeline registers.
REQ-004 mem_en  in  1  memory enable.
REQ-005 mem_rw  in  1  0 = write, 1 = read.
REQ-006 mem_addr  in  32  byte offset into instruction memory (caller removes PC base).
REQ-007 mem_wdata  in  32  write data.
REQ-008 mem_rdata  out  32  memory read data (combinational).
REQ-009 instr_q  out  32  registered fetched instruction.
REQ-010 Registered decode outputs (all from the decode stage register): alu_op 1, mem_op 1, branch_op 1, nop 1, op_type 6, rs 5, rt 5, rd 5, sh_amt 5, func 6, alu_imm 16, branch_imm 26, instr_out 32.

Function
REQ-011 Memory: word array of MEM_WORDS entries, indexed by mem_addr[log2(MEM_WORDS)+1:2]; mem_addr[1:0] and all higher bits are ignored, so addresses wrap modulo MEM_WORDS*4.
REQ-012 Write: when mem_en=1 and mem_rw=0 at a rising edge, store mem_wdata to the addressed word.
REQ-013 Read: mem_rdata = addressed word when mem_en=1 and mem_rw=1, else 32'h0; a word written at edge N is readable immediately after edge N.
REQ-014 Memory contents are not affected by reset; never-written words read as undefined.
REQ-015 Fetch stage: instr_q captures mem_rdata on every rising edge (no enable).
REQ-016 Decoder, combinational from instr_q: op_type=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], sh_amt=[10:6], func=[5:0], alu_imm=[15:0], branch_imm=[25:0], instr_out=instr_q.
REQ-017 nop=1 iff instr_q==32'h0; then alu_op=mem_op=branch_op=0.
REQ-018 branch_op=1 for op_type 0x01-0x07, or op_type 0x00 with func 0x08 (jr) or 0x09 (jalr).
REQ-019 alu_op=1 for non-zero op_type 0x00 instructions not covered by REQ-018, and for op_type 0x08-0x0F.
REQ-020 mem_op=1 for op_type 0x20, 0x21, 0x23, 0x24, 0x25, 0x28, 0x29, 0x2B.
REQ-021 Any other op_type: all four class flags 0; field outputs still extracted.
REQ-022 At most one of alu_op, mem_op, branch_op, nop is 1 at any time.
REQ-023 Decode stage: all REQ-010 outputs are registers loaded from the decoder on every rising edge.
REQ-024 Latency: address applied before edge N -> instr_q valid after edge N -> decode outputs valid after edge N+1; one new instruction accepted per cycle.

Reset
REQ-025 While reset=1, instr_q and all decode outputs are 0 (including nop=0), asynchronously, independent of clock.
REQ-026 After reset deasserts, the first rising edge loads instr_q normally; decode outputs reflect instr_q one edge later.
REQ-027 Reset mid-stream discards in-flight instructions only; memory retains contents.

Verification
REQ-028 Assert reset between edges -> instr_q and all decode outputs 0 immediately, before the next edge.
REQ-029 Write 0x012A4020 at addr 0 (rw=0), then read addr 0 (rw=1) -> after 1 edge instr_q=0x012A4020; after 2nd edge alu_op=1, op_type=0, rs=9, rt=10, rd=8, sh_amt=0, func=0x20.
REQ-030 Stream 0x8FA80004 (lw) -> mem_op=1, op_type=0x23, rs=29, rt=8, alu_imm=0x0004; then 0x08100004 (j) -> branch_op=1, op_type=0x02, branch_imm=0x0100004, on consecutive cycles.
REQ-031 0x00000000 -> nop=1, other flags 0; 0x03E00008 (jr $ra) -> branch_op=1, alu_op=0; 0xFC000000 -> all flags 0.
REQ-032 Write 0xDEADBEEF at addr 4, read addr 4 and addr 0x10004 with MEM_WORDS=16384 -> both return 0xDEADBEEF (wrap); mem_en=0 -> mem_rdata=0.
REQ-033 Pulse reset mid-stream, then re-read addr 4 -> data intact, decode outputs resume after 2 edges.

Source files
------------

// File: rtl/fetch_decode_unit.sv
// Instruction memory feeding a two-stage fetch/decode pipeline.
// Fetch registers the memory read word; decode classifies it and registers the fields.
module fetch_decode_unit #(
    parameter int MEM_WORDS = 16384
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_en,
    input  logic        mem_rw,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic [31:0] instr_q,
    output logic        alu_op,
    output logic        mem_op,
    output logic        branch_op,
    output logic        nop,
    output logic [5:0]  op_type,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  sh_amt,
    output logic [5:0]  func,
    output logic [15:0] alu_imm,
    output logic [25:0] branch_imm,
    output logic [31:0] instr_out
);

    localparam int AW = $clog2(MEM_WORDS);

    logic [31:0]   mem [MEM_WORDS];
    logic [AW-1:0] word_idx;
    logic          unused_addr_bits;

    // Byte offset and bits above the array depth are dropped, so addresses wrap.
    assign word_idx         = mem_addr[AW+1:2];
    assign unused_addr_bits = ^{mem_addr[31:AW+2], mem_addr[1:0]};

    always_ff @(posedge clock) begin
        if (mem_en && !mem_rw) begin
            mem[word_idx] <= mem_wdata;
        end
    end

    assign mem_rdata = (mem_en && mem_rw) ? mem[word_idx] : 32'h0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            instr_q <= 32'h0;
        end else begin
            instr_q <= mem_rdata;
        end
    end

    logic [5:0] d_op;
    logic [5:0] d_func;
    logic       d_alu;
    logic       d_mem;
    logic       d_branch;
    logic       d_nop;

    assign d_op   = instr_q[31:26];
    assign d_func = instr_q[5:0];

    // Class flags are mutually exclusive; the all-zero word is a nop, not an ALU op.
    always_comb begin
        d_alu    = 1'b0;
        d_mem    = 1'b0;
        d_branch = 1'b0;
        d_nop    = (instr_q == 32'h0);
        if (!d_nop) begin
            case (d_op) inside
                6'h00: begin
                    if (d_func == 6'h08 || d_func == 6'h09) begin
                        d_branch = 1'b1;
                    end else begin
                        d_alu = 1'b1;
                    end
                end
                [6'h01:6'h07]: d_branch = 1'b1;
                [6'h08:6'h0F]: d_alu    = 1'b1;
                6'h20, 6'h21, 6'h23, 6'h24,
                6'h25, 6'h28, 6'h29, 6'h2B: d_mem = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            alu_op     <= 1'b0;
            mem_op     <= 1'b0;
            branch_op  <= 1'b0;
            nop        <= 1'b0;
            op_type    <= 6'h0;
            rs         <= 5'h0;
            rt         <= 5'h0;
            rd         <= 5'h0;
            sh_amt     <= 5'h0;
            func       <= 6'h0;
            alu_imm    <= 16'h0;
            branch_imm <= 26'h0;
            instr_out  <= 32'h0;
        end else begin
            alu_op     <= d_alu;
            mem_op     <= d_mem;
            branch_op  <= d_branch;
            nop        <= d_nop;
            op_type    <= d_op;
            rs         <= instr_q[25:21];
            rt         <= instr_q[20:16];
            rd         <= instr_q[15:11];
            sh_amt     <= instr_q[10:6];
            func       <= d_func;
            alu_imm    <= instr_q[15:0];
            branch_imm <= instr_q[25:0];
            instr_out  <= instr_q;
        end
    end

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Bench for fetch_decode_unit: directed cases plus a randomized read/write stream
// compared against an associative-array memory and a two-deep instruction pipeline model.
`timescale 1ns/1ps
module tb_fetch_decode_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        mem_en;
    logic        mem_rw;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [31:0] instr_q;
    logic        alu_op;
    logic        mem_op;
    logic        branch_op;
    logic        nop;
    logic [5:0]  op_type;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sh_amt;
    logic [5:0]  func;
    logic [15:0] alu_imm;
    logic [25:0] branch_imm;
    logic [31:0] instr_out;

    fetch_decode_unit #(.MEM_WORDS(16384)) dut (
        .clock(clock), .reset(reset),
        .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .instr_q(instr_q),
        .alu_op(alu_op), .mem_op(mem_op), .branch_op(branch_op), .nop(nop),
        .op_type(op_type), .rs(rs), .rt(rt), .rd(rd), .sh_amt(sh_amt), .func(func),
        .alu_imm(alu_imm), .branch_imm(branch_imm), .instr_out(instr_out)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    logic [31:0] model_mem [int];
    logic [31:0] exp_iq;
    bit          iq_known;
    logic [31:0] exp_dec;
    bit          dec_known;
    bit          dec_rst;
    logic [31:0] written_addrs [$];

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
        end
    endtask

    function automatic int wordIndex(input logic [31:0] addr);
        return int'((addr >> 2) % 32'd16384);
    endfunction

    // Returns {nop, alu, mem, branch} from the instruction-set classification rules.
    function automatic logic [3:0] classOf(input logic [31:0] ins);
        int op;
        int fn;
        op = int'(ins >> 26);
        fn = int'(ins % 64);
        if (ins == 32'h0) return 4'b1000;
        if ((op >= 1 && op <= 7) || (op == 0 && (fn == 8 || fn == 9))) return 4'b0001;
        if (op == 0 || (op >= 8 && op <= 15)) return 4'b0100;
        if (op == 32 || op == 33 || op == 35 || op == 36 || op == 37 ||
            op == 40 || op == 41 || op == 43) return 4'b0010;
        return 4'b0000;
    endfunction

    task automatic checkDecode();
        logic [31:0] e;
        logic [3:0]  flags;
        e     = dec_rst ? 32'h0 : exp_dec;
        flags = dec_rst ? 4'b0000 : classOf(e);
        checkOutput("flags", {28'h0, nop, alu_op, mem_op, branch_op}, {28'h0, flags});
        checkOutput("op_type", {26'h0, op_type}, e >> 26);
        checkOutput("rs", {27'h0, rs}, (e >> 21) % 32);
        checkOutput("rt", {27'h0, rt}, (e >> 16) % 32);
        checkOutput("rd", {27'h0, rd}, (e >> 11) % 32);
        checkOutput("sh_amt", {27'h0, sh_amt}, (e >> 6) % 32);
        checkOutput("func", {26'h0, func}, e % 64);
        checkOutput("alu_imm", {16'h0, alu_imm}, e % 65536);
        checkOutput("branch_imm", {6'h0, branch_imm}, e % (1 << 26));
        checkOutput("instr_out", instr_out, e);
    endtask

    task automatic driveInputs(input logic en, input logic rw, input logic [31:0] addr, input logic [31:0] wdata);
        mem_en    = en;
        mem_rw    = rw;
        mem_addr  = addr;
        mem_wdata = wdata;
        #1;
        if (en && rw) begin
            if (model_mem.exists(wordIndex(addr))) begin
                checkOutput("mem_rdata", mem_rdata, model_mem[wordIndex(addr)]);
            end
        end else begin
            checkOutput("mem_rdata_idle", mem_rdata, 32'h0);
        end
    endtask

    task automatic stepClock();
        logic [31:0] rd_val;
        bit          rd_known;
        rd_known = 1'b1;
        rd_val   = 32'h0;
        if (mem_en && mem_rw) begin
            rd_known = model_mem.exists(wordIndex(mem_addr));
            if (rd_known) rd_val = model_mem[wordIndex(mem_addr)];
        end
        @(posedge clock);
        if (mem_en && !mem_rw) model_mem[wordIndex(mem_addr)] = mem_wdata;
        exp_dec   = exp_iq;
        dec_known = iq_known;
        dec_rst   = 1'b0;
        exp_iq    = rd_val;
        iq_known  = rd_known;
        @(negedge clock);
        if (iq_known) checkOutput("instr_q", instr_q, exp_iq);
        if (dec_known) checkDecode();
    endtask

    task automatic applyStimulus(input logic en, input logic rw, input logic [31:0] addr, input logic [31:0] wdata);
        driveInputs(en, rw, addr, wdata);
        stepClock();
    endtask

    task automatic writeWord(input logic [31:0] addr, input logic [31:0] data);
        applyStimulus(1'b1, 1'b0, addr, data);
        written_addrs.push_back(addr);
    endtask

    task automatic checkResetState(input string tag);
        exp_iq   = 32'h0;
        iq_known = 1'b1;
        dec_rst  = 1'b1;
        checkOutput(tag, instr_q, 32'h0);
        checkDecode();
    endtask

    // Reset is raised and dropped between clock edges, checked before any edge.
    task automatic pulseReset();
        mem_en = 1'b0;
        #2 reset = 1'b1;
        #1 checkResetState("reset_mid_iq");
        #1 reset = 1'b0;
        @(negedge clock);
    endtask

    function automatic logic [31:0] randomInstr();
        logic [5:0]  op;
        logic [31:0] body;
        int          pick;
        logic [5:0]  mem_ops [8];
        mem_ops = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B};
        body = $urandom;
        pick = $urandom_range(0, 9);
        case (pick)
            0: return 32'h0;
            1: op = 6'h00;
            2: return {6'h00, body[25:6], ($urandom_range(0, 1) == 0) ? 6'h08 : 6'h09};
            3: op = 6'($urandom_range(1, 7));
            4: op = 6'($urandom_range(8, 15));
            5, 6: op = mem_ops[$urandom_range(0, 7)];
            default: op = 6'($urandom_range(0, 63));
        endcase
        return {op, body[25:0]};
    endfunction

    initial begin
        reset     = 1'b1;
        mem_en    = 1'b0;
        mem_rw    = 1'b1;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        dec_known = 1'b0;
        #1 checkResetState("reset_iq");
        repeat (2) @(negedge clock);
        reset = 1'b0;

        writeWord(32'h0, 32'h012A4020);
        applyStimulus(1'b1, 1'b1, 32'h0, 32'h0);
        checkOutput("add_iq", instr_q, 32'h012A4020);
        applyStimulus(1'b0, 1'b1, 32'h0, 32'h0);
        checkOutput("add_alu", {31'h0, alu_op}, 32'h1);
        checkOutput("add_fields", {op_type, rs, rt, rd, sh_amt, func}, {6'h0, 5'd9, 5'd10, 5'd8, 5'd0, 6'h20});

        writeWord(32'h8, 32'h8FA80004);
        writeWord(32'hC, 32'h08100004);
        applyStimulus(1'b1, 1'b1, 32'h8, 32'h0);
        applyStimulus(1'b1, 1'b1, 32'hC, 32'h0);
        checkOutput("lw_class", {mem_op, 5'h0, op_type, rs, rt, alu_imm}, {1'b1, 5'h0, 6'h23, 5'd29, 5'd8, 16'h0004});
        applyStimulus(1'b0, 1'b1, 32'h0, 32'h0);
        checkOutput("j_class", {branch_op, op_type, 26'h0}, {1'b1, 6'h02, 26'h0});
        checkOutput("j_imm", {6'h0, branch_imm}, 32'h0100004);

        writeWord(32'h10, 32'h00000000);
        writeWord(32'h14, 32'h03E00008);
        writeWord(32'h18, 32'hFC000000);
        applyStimulus(1'b1, 1'b1, 32'h10, 32'h0);
        applyStimulus(1'b1, 1'b1, 32'h14, 32'h0);
        checkOutput("nop_flags", {28'h0, nop, alu_op, mem_op, branch_op}, 32'h8);
        applyStimulus(1'b1, 1'b1, 32'h18, 32'h0);
        checkOutput("jr_flags", {28'h0, nop, alu_op, mem_op, branch_op}, 32'h1);
        applyStimulus(1'b0, 1'b1, 32'h0, 32'h0);
        checkOutput("fc_flags", {28'h0, nop, alu_op, mem_op, branch_op}, 32'h0);

        writeWord(32'h4, 32'hDEADBEEF);
        driveInputs(1'b1, 1'b1, 32'h4, 32'h0);
        checkOutput("rd_addr4", mem_rdata, 32'hDEADBEEF);
        stepClock();
        driveInputs(1'b1, 1'b1, 32'h10004, 32'h0);
        checkOutput("rd_wrap", mem_rdata, 32'hDEADBEEF);
        stepClock();
        driveInputs(1'b0, 1'b1, 32'h4, 32'h0);
        checkOutput("rd_disabled", mem_rdata, 32'h0);
        stepClock();

        applyStimulus(1'b1, 1'b1, 32'h8, 32'h0);
        applyStimulus(1'b1, 1'b1, 32'hC, 32'h0);
        pulseReset();
        applyStimulus(1'b1, 1'b1, 32'h4, 32'h0);
        checkOutput("post_rst_iq", instr_q, 32'hDEADBEEF);
        applyStimulus(1'b0, 1'b1, 32'h0, 32'h0);
        checkOutput("post_rst_dec", instr_out, 32'hDEADBEEF);

        for (int i = 0; i < 40; i++) begin
            writeWord(32'($urandom_range(0, 2047)) << 2, randomInstr());
        end

        for (int i = 0; i < 500; i++) begin
            int          r;
            logic [31:0] a;
            r = $urandom_range(0, 19);
            a = written_addrs[$urandom_range(0, written_addrs.size() - 1)];
            a = a | (32'($urandom_range(0, 3)) << 16) | 32'($urandom_range(0, 3));
            if (r < 2) begin
                writeWord(32'($urandom_range(0, 2047)) << 2, randomInstr());
            end else if (r < 4) begin
                applyStimulus(1'b0, 1'($urandom_range(0, 1)), a, $urandom);
            end else if (r == 4) begin
                pulseReset();
            end else begin
                applyStimulus(1'b1, 1'b1, a, 32'h0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
